// File: rtl/mcdf_arbiter_if.sv
// MCDF arbiter bundle: per-channel slave req/ack/val handshake, channel
// configuration from the register block, and the formatter-side packet stream.
interface mcdf_arbiter_if;
    logic        slv0_req_i,    slv1_req_i,    slv2_req_i;
    logic        slv0_val_i,    slv1_val_i,    slv2_val_i;
    logic [31:0] slv0_data_i,   slv1_data_i,   slv2_data_i;
    logic        slv0_en_i,     slv1_en_i,     slv2_en_i;
    logic [1:0]  slv0_prio_i,   slv1_prio_i,   slv2_prio_i;
    logic [2:0]  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i;
    logic        fmt_ready_i;
    logic        a2s0_ack_o,    a2s1_ack_o,    a2s2_ack_o;
    logic        a2f_val_o;
    logic [31:0] a2f_data_o;
    logic [1:0]  a2f_id_o;
    logic        a2f_sop_o;
    logic        a2f_eop_o;
    logic [5:0]  a2f_pkglen_o;
    logic        a2f_busy_o;
    logic        a2f_err_o;

    modport master (
        input  slv0_req_i, slv1_req_i, slv2_req_i,
        input  slv0_val_i, slv1_val_i, slv2_val_i,
        input  slv0_data_i, slv1_data_i, slv2_data_i,
        input  slv0_en_i, slv1_en_i, slv2_en_i,
        input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
        input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        input  fmt_ready_i,
        output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        output a2f_val_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o,
        output a2f_pkglen_o, a2f_busy_o, a2f_err_o
    );

    modport slave (
        output slv0_req_i, slv1_req_i, slv2_req_i,
        output slv0_val_i, slv1_val_i, slv2_val_i,
        output slv0_data_i, slv1_data_i, slv2_data_i,
        output slv0_en_i, slv1_en_i, slv2_en_i,
        output slv0_prio_i, slv1_prio_i, slv2_prio_i,
        output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        output fmt_ready_i,
        input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        input  a2f_val_o, a2f_data_o, a2f_id_o, a2f_sop_o, a2f_eop_o,
        input  a2f_pkglen_o, a2f_busy_o, a2f_err_o
    );
endinterface

// File: rtl/mcdf_arbiter.sv
// Three-channel MCDF packet arbiter: priority grant with round-robin tie-break,
// one-cycle ack, then forwards the granted channel's burst to the formatter.
//
// state  | meaning
// IDLE   | look for an eligible channel while the formatter is ready
// ACK    | one-cycle ack pulse to the winner
// WAIT   | wait up to 4 cycles for the first val beat
// XFER   | forward val beats until the latched length is reached
module mcdf_arbiter (
    input  logic           clk_i,
    input  logic           rstn_i,
    mcdf_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_XFER} state_t;

    state_t      state;
    logic [2:0]  req, val, en, elig;
    logic [1:0]  prio [3];
    logic [2:0]  code [3];
    logic [31:0] data [3];

    logic [1:0]  ptr;
    logic [5:0]  cnt;
    logic [1:0]  tmr;
    logic [2:0]  ack_q;
    logic        val_q, sop_q, eop_q, busy_q, err_q;
    logic [31:0] data_q;
    logic [1:0]  id_q;
    logic [5:0]  len_q;

    logic        win_vld;
    logic [1:0]  win_id, best_prio, c;
    logic        g_val, g_en;

    assign req  = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
    assign val  = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    assign en   = {bus.slv2_en_i,  bus.slv1_en_i,  bus.slv0_en_i};
    assign elig = req & en;

    assign prio[0] = bus.slv0_prio_i;
    assign prio[1] = bus.slv1_prio_i;
    assign prio[2] = bus.slv2_prio_i;
    assign code[0] = bus.slv0_pkglen_i;
    assign code[1] = bus.slv1_pkglen_i;
    assign code[2] = bus.slv2_pkglen_i;
    assign data[0] = bus.slv0_data_i;
    assign data[1] = bus.slv1_data_i;
    assign data[2] = bus.slv2_data_i;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    function automatic logic [5:0] len_decode(input logic [2:0] cd);
        if (cd[2]) return 6'd32;
        case (cd[1:0])
            2'd0:    return 6'd4;
            2'd1:    return 6'd8;
            2'd2:    return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    // Scan in round-robin order from ptr+1; strict '<' keeps the earliest
    // channel in that order on a priority tie.
    always_comb begin
        win_vld   = 1'b0;
        win_id    = 2'd0;
        best_prio = 2'd3;
        c         = ptr;
        for (int k = 0; k < 3; k++) begin
            c = next_ch(c);
            if (elig[c] && (!win_vld || prio[c] < best_prio)) begin
                win_vld   = 1'b1;
                win_id    = c;
                best_prio = prio[c];
            end
        end
    end

    assign g_val = val[id_q];
    assign g_en  = en[id_q];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= S_IDLE;
            ptr    <= 2'd2;
            cnt    <= 6'd0;
            tmr    <= 2'd0;
            ack_q  <= 3'b000;
            val_q  <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            data_q <= 32'd0;
            id_q   <= 2'd0;
            len_q  <= 6'd0;
        end else begin
            ack_q <= 3'b000;
            val_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (win_vld && bus.fmt_ready_i) begin
                        ack_q  <= 3'b001 << win_id;
                        id_q   <= win_id;
                        ptr    <= win_id;
                        len_q  <= len_decode(code[win_id]);
                        busy_q <= 1'b1;
                        state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!g_en) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmr   <= 2'd3;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!g_en) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (g_val) begin
                        val_q  <= 1'b1;
                        sop_q  <= 1'b1;
                        data_q <= data[id_q];
                        cnt    <= 6'd1;
                        if (len_q == 6'd1) begin
                            eop_q <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_XFER;
                        end
                    end else if (tmr == 2'd0) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmr <= tmr - 2'd1;
                    end
                end
                S_XFER: begin
                    if (!g_en) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (g_val) begin
                        val_q  <= 1'b1;
                        data_q <= data[id_q];
                        if (cnt + 6'd1 == len_q) begin
                            eop_q <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.a2s0_ack_o   = ack_q[0];
    assign bus.a2s1_ack_o   = ack_q[1];
    assign bus.a2s2_ack_o   = ack_q[2];
    assign bus.a2f_val_o    = val_q;
    assign bus.a2f_data_o   = data_q;
    assign bus.a2f_id_o     = id_q;
    assign bus.a2f_sop_o    = sop_q;
    assign bus.a2f_eop_o    = eop_q;
    assign bus.a2f_pkglen_o = len_q;
    assign bus.a2f_busy_o   = busy_q;
    assign bus.a2f_err_o    = err_q;
endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: single packet, priority, round-robin,
// stall/clamp, timeout, enable abort, formatter gating and async reset.
module tb_mcdf_arbiter;
    logic clk_i = 1'b0;
    logic rstn_i;

    logic [2:0]  req, val, en;
    logic [1:0]  prio [3];
    logic [2:0]  code [3];
    logic [31:0] data [3];
    logic        fmt_ready;
    logic [2:0]  ack;

    int checks = 0;
    int errors = 0;

    mcdf_arbiter_if bus();
    mcdf_arbiter dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    assign bus.slv0_req_i    = req[0];
    assign bus.slv1_req_i    = req[1];
    assign bus.slv2_req_i    = req[2];
    assign bus.slv0_val_i    = val[0];
    assign bus.slv1_val_i    = val[1];
    assign bus.slv2_val_i    = val[2];
    assign bus.slv0_data_i   = data[0];
    assign bus.slv1_data_i   = data[1];
    assign bus.slv2_data_i   = data[2];
    assign bus.slv0_en_i     = en[0];
    assign bus.slv1_en_i     = en[1];
    assign bus.slv2_en_i     = en[2];
    assign bus.slv0_prio_i   = prio[0];
    assign bus.slv1_prio_i   = prio[1];
    assign bus.slv2_prio_i   = prio[2];
    assign bus.slv0_pkglen_i = code[0];
    assign bus.slv1_pkglen_i = code[1];
    assign bus.slv2_pkglen_i = code[2];
    assign bus.fmt_ready_i   = fmt_ready;
    assign ack = {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int ch, input int b);
        return 32'hA000_0000 | (32'(ch) << 24) | 32'(b & 255);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},    32'(ack), 32'd0);
        chk({tag, "_val"},    32'(bus.a2f_val_o), 32'd0);
        chk({tag, "_data"},   bus.a2f_data_o, 32'd0);
        chk({tag, "_id"},     32'(bus.a2f_id_o), 32'd0);
        chk({tag, "_sop"},    32'(bus.a2f_sop_o), 32'd0);
        chk({tag, "_eop"},    32'(bus.a2f_eop_o), 32'd0);
        chk({tag, "_pkglen"}, 32'(bus.a2f_pkglen_o), 32'd0);
        chk({tag, "_busy"},   32'(bus.a2f_busy_o), 32'd0);
        chk({tag, "_err"},    32'(bus.a2f_err_o), 32'd0);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        req    = 3'b000;
        val    = 3'b000;
        #1;
        tick();
        rstn_i = 1'b1;
        tick();
    endtask

    // Waits (bounded) for an ack and checks it is the expected one-hot grant.
    task automatic wait_ack(input int ch);
        int i = 0;
        while (ack == 3'b000 && i < 40) begin
            tick();
            i++;
        end
        chk("grant_ch", 32'(ack), 32'd1 << ch);
        chk("grant_id", 32'(bus.a2f_id_o), 32'(ch));
        chk("grant_busy", 32'(bus.a2f_busy_o), 32'd1);
    endtask

    // Acts as the granted slave: n beats, optional stall, noise val on other channels.
    task automatic serve(input int ch, input int n, input int stall_at, input int stall_len,
                         input bit drop_req, input bit expect_idle);
        wait_ack(ch);
        chk("pkglen", 32'(bus.a2f_pkglen_o), 32'(n));
        if (drop_req) req[ch] = 1'b0;
        tick();
        chk("ack_one_cycle", 32'(ack), 32'd0);
        tick();
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                val[ch] = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk("stall_val", 32'(bus.a2f_val_o), 32'd0);
                end
            end
            val = 3'b111;
            for (int c = 0; c < 3; c++) data[c] = pat(c, b);
            tick();
            chk("beat_val",  32'(bus.a2f_val_o), 32'd1);
            chk("beat_data", bus.a2f_data_o, pat(ch, b));
            chk("beat_id",   32'(bus.a2f_id_o), 32'(ch));
            chk("beat_sop",  32'(bus.a2f_sop_o), 32'(b == 0));
            chk("beat_eop",  32'(bus.a2f_eop_o), 32'(b == n - 1));
            chk("beat_err",  32'(bus.a2f_err_o), 32'd0);
        end
        val = 3'b000;
        tick();
        chk("post_val", 32'(bus.a2f_val_o), 32'd0);
        chk("post_eop", 32'(bus.a2f_eop_o), 32'd0);
        if (expect_idle) chk("post_busy", 32'(bus.a2f_busy_o), 32'd0);
    endtask

    initial begin
        rstn_i    = 1'b0;
        req       = 3'b000;
        val       = 3'b000;
        en        = 3'b111;
        fmt_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            prio[c] = 2'd1;
            code[c] = 3'd0;
            data[c] = 32'd0;
        end
        #2;
        check_reset("rst");
        tick();
        rstn_i = 1'b1;
        tick();

        // single request on ch1
        req[1] = 1'b1;
        serve(1, 4, -1, 0, 1'b1, 1'b1);

        // priority: ch2 (prio 0) before ch0 (prio 2)
        do_reset();
        prio[0] = 2'd2; prio[2] = 2'd0;
        req = 3'b101;
        serve(2, 4, -1, 0, 1'b1, 1'b0);
        serve(0, 4, -1, 0, 1'b1, 1'b1);

        // round-robin among equal priorities
        do_reset();
        for (int c = 0; c < 3; c++) prio[c] = 2'd1;
        req = 3'b111;
        serve(0, 4, -1, 0, 1'b0, 1'b0);
        serve(1, 4, -1, 0, 1'b0, 1'b0);
        serve(2, 4, -1, 0, 1'b0, 1'b0);
        serve(0, 4, -1, 0, 1'b0, 1'b0);
        serve(1, 4, -1, 0, 1'b0, 1'b0);

        // clamp code 7 to 32, stall mid-burst, length latched, fmt_ready ignored
        do_reset();
        code[0] = 3'd7;
        req[0]  = 1'b1;
        wait_ack(0);
        code[0]   = 3'd0;
        fmt_ready = 1'b0;
        serve(0, 32, 10, 3, 1'b1, 1'b1);
        fmt_ready = 1'b1;

        // start timeout, then re-grant to ch1
        do_reset();
        req[1] = 1'b1;
        wait_ack(1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("to_no_err", 32'(bus.a2f_err_o), 32'd0);
        end
        tick();
        chk("to_err", 32'(bus.a2f_err_o), 32'd1);
        chk("to_busy", 32'(bus.a2f_busy_o), 32'd0);
        tick();
        chk("to_err_pulse", 32'(bus.a2f_err_o), 32'd0);
        chk("to_regrant", 32'(ack), 32'b010);
        serve(1, 4, -1, 0, 1'b1, 1'b1);

        // enable drop on the third of 8 beats
        do_reset();
        code[2] = 3'd1;
        req[2]  = 1'b1;
        wait_ack(2);
        chk("ab_pkglen", 32'(bus.a2f_pkglen_o), 32'd8);
        req[2] = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            val = 3'b111;
            for (int c = 0; c < 3; c++) data[c] = pat(c, b);
            tick();
            chk("ab_beat_data", bus.a2f_data_o, pat(2, b));
        end
        en[2] = 1'b0;
        tick();
        chk("ab_val", 32'(bus.a2f_val_o), 32'd0);
        chk("ab_eop", 32'(bus.a2f_eop_o), 32'd0);
        chk("ab_err", 32'(bus.a2f_err_o), 32'd1);
        chk("ab_busy", 32'(bus.a2f_busy_o), 32'd0);
        val = 3'b000;
        tick();
        chk("ab_err_pulse", 32'(bus.a2f_err_o), 32'd0);
        chk("ab_busy_low", 32'(bus.a2f_busy_o), 32'd0);
        chk("ab_no_ack", 32'(ack), 32'd0);
        en[2] = 1'b1;
        code[2] = 3'd0;

        // formatter gating, then async reset mid-packet
        do_reset();
        fmt_ready = 1'b0;
        req[0]    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_no_ack", 32'(ack), 32'd0);
        end
        fmt_ready = 1'b1;
        tick();
        chk("gate_ack", 32'(ack), 32'b001);
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            val = 3'b111;
            for (int c = 0; c < 3; c++) data[c] = pat(c, b);
            tick();
            chk("pre_rst_val", 32'(bus.a2f_val_o), 32'd1);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset("async_rst");
        val = 3'b000;
        tick();
        rstn_i = 1'b1;
        serve(0, 4, -1, 0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcdf_arbiter.md
# mcdf_arbiter

Three-channel packet arbiter of the MCDF datapath, sitting between the per-channel slave FIFOs and the formatter. It collects channel requests, picks one channel by programmable priority with round-robin tie-break, and issues a one-cycle acknowledge. It then forwards the resulting burst of valid words to the formatter, tagged with channel ID and start/end-of-packet markers. It is the granting end of the slave req/ack/val handshake.

## Interface
- NCH, 3, number of channels (fixed at 3; ID width 2).
- clk_i  input  1  clock; all logic on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- slv0_req_i / slv1_req_i / slv2_req_i  input  1 each  channel holds ≥ one packet.
- slv0_val_i / slv1_val_i / slv2_val_i  input  1 each  channel data word valid.
- slv0_data_i / slv1_data_i / slv2_data_i  input  32 each  channel data word.
- slv0_en_i / slv1_en_i / slv2_en_i  input  1 each  channel enable from register block.
- slv0_prio_i / slv1_prio_i / slv2_prio_i  input  2 each  priority; 0 = highest.
- slv0_pkglen_i / slv1_pkglen_i / slv2_pkglen_i  input  3 each  packet length code.
- fmt_ready_i  input  1  formatter can accept a full packet.
- a2s0_ack_o / a2s1_ack_o / a2s2_ack_o  output  1 each  one-cycle grant pulse to channel.
- a2f_val_o  output  1  forwarded word valid.
- a2f_data_o  output  32  forwarded word.
- a2f_id_o  output  2  source channel ID (0..2).
- a2f_sop_o  output  1  first word of packet.
- a2f_eop_o  output  1  last word of packet.
- a2f_pkglen_o  output  6  latched packet length in words.
- a2f_busy_o  output  1  high from grant until last word forwarded.
- a2f_err_o  output  1  one-cycle pulse on start timeout.

## Operation
- States: IDLE, ACK, WAIT, XFER.
- IDLE: eligible channel = req & en. If any eligible and fmt_ready_i = 1, choose the winner, latch ID and length, and go to ACK. Otherwise stay.
- Winner selection: the lowest prio value wins. On a tie, round-robin starts from the channel after the last granted one. After reset the last granted channel is 2, so channel 0 wins the first tie.
- Length decode: code 0→4, 1→8, 2→16, 3→32 words. Codes 4..7 are clamped to 32. Length is latched at grant; later changes to pkglen_i do not affect the packet in flight.
- ACK: assert the winner's ack for exactly one cycle, then go to WAIT. Only one ack bit is ever high.
- WAIT: wait for the granted channel's val.
  - On val, forward the word, set the beat counter to 1, and go to XFER. If the length is 1 (never occurs), go directly to IDLE.
  - If no val arrives within 4 cycles after the ack cycle, pulse a2f_err_o and return to IDLE.
- XFER: forward each val beat of the granted channel and increment the counter. Cycles with val = 0 are stalls; the counter holds and there is no timeout. The beat where counter + 1 = length is the last beat; after it, go to IDLE.
- val from non-granted channels is ignored.
- If the granted channel's en drops during ACK, WAIT or XFER, abort to IDLE with no eop. a2f_err_o pulses for one cycle.
- Round-robin pointer updates at grant.

## Timing
- Reset values: all acks 0, a2f_val_o 0, a2f_data_o 0, a2f_id_o 0, a2f_sop_o 0, a2f_eop_o 0, a2f_pkglen_o 0, a2f_busy_o 0, a2f_err_o 0. State resets to IDLE, pointer to 2, counter to 0.
- All outputs are registered.
- IDLE decision at edge T, ack high during cycle T+1.
- The slave presents val from cycle T+3 (req/ack/val pipeline). Each forwarded word appears one cycle after its slv val/data.
- a2f_sop_o is high with the first forwarded word. a2f_eop_o is high with the last. Both are qualified by a2f_val_o.
- a2f_busy_o rises with ack and falls the cycle after the eop word.
- Minimum gap between packets: the last word is forwarded at cycle E, then IDLE; the next ack is no earlier than E+1.
- fmt_ready_i is sampled only in IDLE. Dropping it mid-packet does not stall the transfer.
- Asynchronous reset mid-packet returns every output to its reset value immediately. No partial eop is produced.

## Test plan
- Single request: ch1 req, prio 1, code 0, fmt_ready 1. Expect:
  - one-cycle a2s1_ack_o;
  - 4 a2f_val_o beats with id = 1, sop on beat 1, eop on beat 4;
  - a2f_pkglen_o = 4;
  - busy falls the cycle after eop.
- Priority: ch0 prio 2, ch2 prio 0, both req. Expect ch2 granted first; ch0 granted after ch2's eop.
- Round-robin: all three req, prio 1, continuously. Expect grant order 0, 1, 2, 0, 1 across 5 packets.
- Stall and clamp: ch0 code 7 (32 words), with slv val deasserted 3 cycles mid-burst. Expect:
  - exactly 32 forwarded words, eop on the 32nd;
  - no err.
- Timeout and abort:
  - Ack ch1 with no val for 5 cycles. Expect an a2f_err_o pulse, return to IDLE, and re-grant to ch1 if its req is still high.
  - Separately, drop slv2_en_i at beat 3 of 8. Expect err pulse, no eop, busy low.
- Gating and reset: fmt_ready_i 0 with ch0 req. Expect no ack. Raise fmt_ready_i and assert rstn_i low during beat 2. Expect all outputs to return to reset values asynchronously, and a normal grant after reset release.
